// File: rtl/input_debouncer.sv
// input_debouncer: multi-channel button/switch conditioner.
// Each channel has a reset-aware synchroniser, an optional polarity inversion,
// a stability counter that accepts a new level only after it has been held for
// DEBOUNCE_CYCLES, registered rise/fall pulses, and an optional long-press pulse.
module input_debouncer #(
    parameter int unsigned             NUM_INPUTS        = 2,
    parameter int unsigned             SYNC_STAGES       = 2,
    parameter int unsigned             DEBOUNCE_CYCLES   = 120000,
    parameter int unsigned             LONG_PRESS_CYCLES = 0,
    parameter logic [NUM_INPUTS-1:0]   INVERT_MASK       = '0,
    parameter logic [NUM_INPUTS-1:0]   RESET_VALUE       = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_INPUTS-1:0] raw_in,
    output logic [NUM_INPUTS-1:0] level,
    output logic [NUM_INPUTS-1:0] rise,
    output logic [NUM_INPUTS-1:0] fall,
    output logic [NUM_INPUTS-1:0] long_press
);

    localparam int unsigned           CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    // Synchroniser reset value is pre-inverted so s equals level right after reset.
    localparam logic [NUM_INPUTS-1:0] SYNC_RST = RESET_VALUE ^ INVERT_MASK;

    logic [SYNC_STAGES-1:0] sync_q [NUM_INPUTS];
    logic [NUM_INPUTS-1:0]  s_w;

    logic [CNT_W-1:0]       cnt_q  [NUM_INPUTS];
    logic [CNT_W-1:0]       cnt_d  [NUM_INPUTS];
    logic [NUM_INPUTS-1:0]  level_q, level_d;
    logic [NUM_INPUTS-1:0]  rise_q,  rise_d;
    logic [NUM_INPUTS-1:0]  fall_q,  fall_d;

    // Shift raw pins through the per-channel synchroniser chain
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                sync_q[i] <= {SYNC_STAGES{SYNC_RST[i]}};
            end
        end else begin
            for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw_in[i]};
            end
        end
    end

    // Polarity-corrected synchronised sample of each channel
    always_comb begin
        s_w = '0;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            s_w[i] = sync_q[i][SYNC_STAGES-1] ^ INVERT_MASK[i];
        end
    end

    // Stability counter: accept s only after it has differed from level long enough
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            if (s_w[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                cnt_d[i]   = '0;
                level_d[i] = s_w[i];
                rise_d[i]  = s_w[i];
                fall_d[i]  = ~s_w[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Debounce state and edge-pulse registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            level_q <= RESET_VALUE;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

    generate
        if (LONG_PRESS_CYCLES > 0) begin : g_long
            localparam int unsigned      HOLD_W    = $clog2(LONG_PRESS_CYCLES + 1);
            localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
            localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

            logic [HOLD_W-1:0]     hcnt_q [NUM_INPUTS];
            logic [HOLD_W-1:0]     hcnt_d [NUM_INPUTS];
            logic [NUM_INPUTS-1:0] fired_q, fired_d;
            logic [NUM_INPUTS-1:0] lp_q,    lp_d;

            // Hold timer: count high cycles, fire once, re-arm when level drops
            always_comb begin
                hcnt_d  = hcnt_q;
                fired_d = fired_q;
                lp_d    = '0;
                for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                    if (!level_q[i]) begin
                        hcnt_d[i]  = '0;
                        fired_d[i] = 1'b0;
                    end else if (!fired_q[i]) begin
                        if (hcnt_q[i] == HOLD_LAST) begin
                            lp_d[i]    = 1'b1;
                            fired_d[i] = 1'b1;
                        end else begin
                            hcnt_d[i] = hcnt_q[i] + HOLD_ONE;
                        end
                    end
                end
            end

            // Hold timer registers
            always_ff @(posedge clock) begin
                if (!reset) begin
                    fired_q <= '0;
                    lp_q    <= '0;
                    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                        hcnt_q[i] <= '0;
                    end
                end else begin
                    fired_q <= fired_d;
                    lp_q    <= lp_d;
                    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                        hcnt_q[i] <= hcnt_d[i];
                    end
                end
            end

            assign long_press = lp_q;
        end else begin : g_no_long
            assign long_press = '0;
        end
    endgenerate

endmodule

// File: tb/tb_input_debouncer.sv
// Testbench for input_debouncer: directed scenarios plus random pin activity,
// all cycles compared against a window-based behavioural model.
module tb_input_debouncer;

    localparam int        NI  = 2;
    localparam int        SS  = 2;
    localparam int        DB  = 4;
    localparam int        LP  = 10;
    localparam logic [1:0] INV = 2'b10;
    localparam logic [1:0] RV  = 2'b00;

    logic       clock  = 1'b0;
    logic       reset  = 1'b0;
    logic [1:0] raw_in = 2'b10;
    logic [1:0] level, rise, fall, long_press;

    input_debouncer #(
        .NUM_INPUTS       (NI),
        .SYNC_STAGES      (SS),
        .DEBOUNCE_CYCLES  (DB),
        .LONG_PRESS_CYCLES(LP),
        .INVERT_MASK      (INV),
        .RESET_VALUE      (RV)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .raw_in    (raw_in),
        .level     (level),
        .rise      (rise),
        .fall      (fall),
        .long_press(long_press)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // s at an edge is the polarity-corrected pin value sampled SS edges earlier;
    // level flips once the last DB s-samples all disagree with it;
    // long_press fires LP edges after the rise if level is still high.
    bit [1:0] dq [SS];
    bit       win [NI][DB];
    int       wcnt [NI];
    longint   edge_no = 0;
    longint   rise_edge [NI];
    bit [1:0] m_level = RV, m_rise = '0, m_fall = '0, m_lp = '0;
    bit [1:0] s_now, prev_level;
    bit       all_diff;

    initial begin
        for (int c = 0; c < NI; c++) rise_edge[c] = -1000;
    end

    always @(posedge clock) begin
        edge_no++;
        if (!reset) begin
            for (int k = 0; k < SS; k++) dq[k] = RV;
            for (int c = 0; c < NI; c++) wcnt[c] = 0;
            m_level = RV; m_rise = '0; m_fall = '0; m_lp = '0;
        end else begin
            s_now = dq[0];
            for (int k = 0; k < SS - 1; k++) dq[k] = dq[k+1];
            dq[SS-1] = raw_in ^ INV;
            prev_level = m_level;
            m_rise = '0; m_fall = '0; m_lp = '0;
            for (int c = 0; c < NI; c++) begin
                if (prev_level[c] && (edge_no - rise_edge[c] == LP)) m_lp[c] = 1'b1;
                for (int k = 0; k < DB - 1; k++) win[c][k] = win[c][k+1];
                win[c][DB-1] = s_now[c];
                if (wcnt[c] < DB) wcnt[c]++;
                all_diff = (wcnt[c] == DB);
                for (int k = 0; k < DB; k++) if (win[c][k] == prev_level[c]) all_diff = 1'b0;
                if (all_diff) begin
                    m_level[c] = s_now[c];
                    if (s_now[c]) begin
                        m_rise[c] = 1'b1;
                        rise_edge[c] = edge_no;
                    end else begin
                        m_fall[c] = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle checker ----------------
    bit chk_en = 1'b0;
    int n_rise [NI];
    int n_fall [NI];
    int n_lp   [NI];

    always @(negedge clock) begin
        if (chk_en) begin
            check_eq("level", level, m_level);
            check_eq("rise", rise, m_rise);
            check_eq("fall", fall, m_fall);
            check_eq("long_press", long_press, m_lp);
            check_eq("rise_fall_excl", rise & fall, 0);
            for (int c = 0; c < NI; c++) begin
                n_rise[c] += rise[c];
                n_fall[c] += fall[c];
                n_lp[c]   += long_press[c];
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic clr();
        for (int c = 0; c < NI; c++) begin
            n_rise[c] = 0; n_fall[c] = 0; n_lp[c] = 0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int d;
    bit found;

    initial begin
        clr();
        // Reset with idle pins (channel 1 is active-low, so raw 1 = released)
        reset  = 1'b0;
        raw_in = 2'b10;
        repeat (3) @(posedge clock);
        @(negedge clock); #1;
        chk_en = 1'b1;
        reset  = 1'b1;
        check_eq("reset_level", level, RV);
        cycles(20);
        check_eq("idle_rises", n_rise[0] + n_rise[1], 0);
        check_eq("idle_falls", n_fall[0] + n_fall[1], 0);

        // Clean step on channel 0: visible 5 edges after first sample
        clr();
        raw_in = 2'b11;
        @(posedge clock);
        repeat (5) @(posedge clock);
        #1;
        check_eq("step_rise_E5", rise[0], 1);
        check_eq("step_level_E5", level[0], 1);
        @(posedge clock); #1;
        check_eq("step_rise_E6", rise[0], 0);
        check_eq("step_ch1_level", level[1], 0);
        @(negedge clock); #1;
        raw_in = 2'b10;
        cycles(12);

        // Glitch of 3 cycles rejected, 4-cycle pulse accepted
        clr();
        raw_in = 2'b11; cycles(3);
        raw_in = 2'b10; cycles(12);
        check_eq("glitch3_rises", n_rise[0], 0);
        raw_in = 2'b11; cycles(4);
        raw_in = 2'b10; cycles(12);
        check_eq("pulse4_rises", n_rise[0], 1);
        check_eq("pulse4_falls", n_fall[0], 1);

        // Chatter on inverted channel 1, then settle pressed
        clr();
        for (int t = 0; t < 10; t++) begin
            raw_in[1] = ~raw_in[1];
            cycles(2);
        end
        raw_in[1] = 1'b0;
        cycles(15);
        check_eq("chatter_rises", n_rise[1], 1);
        check_eq("chatter_falls", n_fall[1], 0);
        raw_in[1] = 1'b1;
        cycles(12);
        check_eq("chatter_release", n_fall[1], 1);

        // Long press on channel 0
        clr();
        raw_in[0] = 1'b1;
        found = 1'b0;
        for (int t = 0; t < 30 && !found; t++) begin
            cycles(1);
            if (rise[0]) found = 1'b1;
        end
        d = -1;
        if (found) begin
            d = 0;
            while (!long_press[0] && d <= 40) begin
                cycles(1);
                d++;
            end
        end
        check_eq("lp_delay", d, LP);
        cycles(50);
        check_eq("lp_count", n_lp[0], 1);
        raw_in[0] = 1'b0;
        cycles(12);
        check_eq("lp_release_fall", n_fall[0], 1);

        // Reset while the counter is at 2: no pulse survives
        clr();
        raw_in = 2'b11;
        cycles(4);
        reset = 1'b0;
        cycles(2);
        raw_in = 2'b10;
        reset  = 1'b1;
        cycles(10);
        check_eq("midreset_level", level, RV);
        check_eq("midreset_rises", n_rise[0], 0);

        // Simultaneous events: press channel 1 first, then step both together
        raw_in = 2'b00;
        cycles(12);
        clr();
        raw_in = 2'b11;
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            cycles(1);
            if (rise[0] || fall[1]) found = 1'b1;
        end
        check_eq("simul_rise", rise, 2'b01);
        check_eq("simul_fall", fall, 2'b10);
        raw_in = 2'b10;
        cycles(15);

        // Random pin activity with occasional resets
        repeat (400) begin
            raw_in = 2'($urandom);
            reset  = ($urandom_range(0, 60) == 0) ? 1'b0 : 1'b1;
            cycles($urandom_range(1, ($urandom_range(0, 3) == 0) ? 20 : 6));
        end
        reset = 1'b1;
        cycles(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Parametrised multi-channel input conditioner for board-level buttons and switches.
- Sits between the raw FPGA pins and the SoC reset, halt and GPIO inputs.
- Replaces single-flop "debouncing" with a per-channel synchroniser, a stability counter, edge pulses and long-press detection.
- One instance serves all buttons on a board; each channel is independent.

Parameters:
NUM_INPUTS, 2, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DEBOUNCE_CYCLES, 120000, consecutive stable cycles required to accept a new level (>=1)
LONG_PRESS_CYCLES, 0, cycles the debounced level must stay 1 before long_press fires; 0 disables the feature
INVERT_MASK, all zeros, NUM_INPUTS bits; bit i=1 inverts channel i after synchronisation (for active-low buttons)
RESET_VALUE, all zeros, NUM_INPUTS bits; debounced level of each channel during and after reset

Ports:
clock  input  1  system clock; all state is clocked on its rising edge
reset  input  1  synchronous, active-low reset (0 = reset asserted)
raw_in  input  NUM_INPUTS  asynchronous raw pin levels
level  output  NUM_INPUTS  debounced, polarity-corrected level
rise  output  NUM_INPUTS  one-cycle pulse when level goes 0->1
fall  output  NUM_INPUTS  one-cycle pulse when level goes 1->0
long_press  output  NUM_INPUTS  one-cycle pulse once per high period, after LONG_PRESS_CYCLES

Behaviour:
Reset (reset==0 at a clock edge):
- Synchroniser flops of channel i load RESET_VALUE[i]^INVERT_MASK[i], so no spurious edge occurs after release.
- level loads RESET_VALUE.
- rise, fall and long_press load 0.
- All counters and the fired flags load 0.
- Reset asserted mid-count abandons the count; no pulse is produced.

Synchronisation:
- s = last synchroniser stage XOR INVERT_MASK[i].
- A raw change reaches s after SYNC_STAGES edges.

Debounce, per channel (two implicit states, STABLE and COUNTING):
- If s==level: cnt<=0 (STABLE).
- If s!=level and cnt<DEBOUNCE_CYCLES-1: cnt<=cnt+1 (COUNTING).
- If s!=level and cnt==DEBOUNCE_CYCLES-1: level<=s, cnt<=0. rise or fall is asserted on the same edge and is visible in the same cycle as the new level.
- Counter width: $clog2(DEBOUNCE_CYCLES+1). The counter never exceeds DEBOUNCE_CYCLES-1.
- Any return of s to level during COUNTING restarts the count from 0. A pulse shorter than DEBOUNCE_CYCLES cycles (measured at s) is fully rejected.
- Latency: a clean step sampled first at edge E changes level at edge E+SYNC_STAGES+DEBOUNCE_CYCLES-1.
- DEBOUNCE_CYCLES=1: level follows s with one register delay.

Edge pulses:
- rise and fall are registered and high for exactly one cycle.
- rise and fall are never both high on the same channel.

Long press (only when LONG_PRESS_CYCLES>0):
- While level==1 and fired==0: hcnt increments.
- When hcnt==LONG_PRESS_CYCLES-1: long_press pulses for one cycle, fired<=1, and hcnt holds.
- When level==0: hcnt<=0 and fired<=0.
- Only one long_press pulse per high period, regardless of hold duration.
- long_press never coincides with rise. With LONG_PRESS_CYCLES=1 it fires on the cycle after rise.
- hcnt width: $clog2(LONG_PRESS_CYCLES+1).
- If LONG_PRESS_CYCLES==0, long_press is constant 0 and no hold counter is generated.

Channels are fully independent; simultaneous events on different channels are all reported in the same cycle.

Test Plan:
Bench parameters: NUM_INPUTS=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10, INVERT_MASK=2'b10, RESET_VALUE=2'b00, unless a scenario states otherwise.
- Reset: hold reset=0 for 3 cycles with raw_in=2'b10, then release -> level=00 and rise/fall/long_press=00 through 20 idle cycles.
- Clean step: raw_in[0] 0->1, first sampled at edge E -> level[0]=1 and rise[0]=1 at edge E+5. rise[0] is low at E+6. No effect on channel 1.
- Glitch: raw_in[0]=1 for 3 cycles, then 0 -> level[0] stays 0, no rise. A 4-cycle pulse -> rise, then a fall 4 cycles after s returns low.
- Chatter: toggle raw_in[1] every 2 cycles for 20 cycles, then hold raw_in[1]=0 -> exactly one rise[1] (inverted channel), no intermediate pulses.
- Long press: hold raw_in[0]=1 -> rise[0] at t, long_press[0] single pulse at t+10, none thereafter for 50 cycles. Release -> fall[0].
- Reset mid-count and simultaneous events: assert reset when cnt==2 -> no pulse, level=RESET_VALUE. Step both channels on the same edge -> rise[0] and fall[1]... → per inverted polarity, both reported in the same cycle.
